// File: rtl/or_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : or_accumulator_if
// Description : Stream bundle for or_accumulator: input valid/ready beat with
//               flush, and the registered result valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
interface or_accumulator_if #(
  parameter int BITS = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            out_any;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_any
  );

  // Accumulator side
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_any
  );
endinterface
`default_nettype wire

// File: rtl/or_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : or_accumulator
// Description : ORs every group of NUM accepted input beats into one result
//               word held in a registered valid/ready output stage. The next
//               group accumulates while a previous result waits downstream.
//               The interface BITS parameter must equal this module's BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module or_accumulator #(
  parameter int NUM  = 4,
  parameter int BITS = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  or_accumulator_if.slave   bus
);

  localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NUM - 1);

  logic [BITS-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [BITS-1:0]  r_out_data;
  logic             r_out_any;

  logic             w_last;
  logic             w_in_ready;
  logic             w_accept;
  logic [BITS-1:0]  w_sum;
  logic             w_load;

  // Handshake and combined word; in_ready depends only on state and out_ready
  always_comb begin
    w_last     = (r_cnt == C_LAST_IDX);
    w_in_ready = !w_last || !r_out_valid || bus.out_ready;
    w_accept   = bus.in_valid && w_in_ready;
    w_sum      = r_acc | bus.in_data;
    // A flushed last beat is discarded and must not produce a result
    w_load     = w_accept && w_last && !bus.flush;
  end

  // Group accumulator and beat index; flush wins over an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output register: a load in the drain cycle keeps valid high (no bubble)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_any   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_any   <= |w_sum;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_any   = r_out_any;

endmodule
`default_nettype wire
